gmii_tx_framer: RTL and testbench
=================================

GMII_TX_FRAMER -- requirements
Module: gmii_tx_framer

Interface
REQ-001 SHALL have parameter MIN_FRAME, default 60, minimum frame length in bytes (data plus pad, FCS excluded).
REQ-002 SHALL have parameter IFG, default 12, inter-frame gap in clock cycles with o_TxEN low.
REQ-003 SHALL have one clock and one reset: asynchronous, active-high reset.
REQ-004 i_TxClk  input  1  GMII transmit clock (125 MHz); all logic on its rising edge.
REQ-005 i_Reset  input  1  asynchronous active-high reset.
REQ-006 i8_Data  input  8  payload byte (destination MAC first).
REQ-007 i_Valid  input  1  i8_Data valid.
REQ-008 i_Last  input  1  i8_Data is the final payload byte.
REQ-009 i_Err  input  1  byte is errored; propagate on o_TxER.
REQ-010 o_Ready  output  1  byte accepted on an edge where i_Valid&o_Ready.
REQ-011 o8_TxD  output  8  GMII TXD.
REQ-012 o_TxEN  output  1  GMII TX_EN.
REQ-013 o_TxER  output  1  GMII TX_ER.
REQ-014 o_Underrun  output  1  one-cycle pulse on payload underrun.

Function
REQ-015 All outputs SHALL be registered; o8_TxD, o_TxEN, o_TxER, o_Ready, o_Underrun SHALL all be 0 after reset.
REQ-016 FSM states SHALL be IDLE, PREAMBLE, SFD, DATA, PAD, FCS, ABORT, GAP.
REQ-017 IDLE: i_Valid=1 sampled -> PREAMBLE next edge; the first 0x55 is driven from that edge, with o_TxEN=1.
REQ-018 PREAMBLE SHALL drive 0x55 for 7 cycles, then SFD drives 0xD5 for 1 cycle, with o_TxEN=1 and o_TxER=0.
REQ-019 o_Ready SHALL be 1 during the SFD cycle and in DATA until the byte with i_Last=1 is accepted; 0 in all other states.
REQ-020 An accepted byte SHALL appear on o8_TxD from the accepting edge, so there are zero bubbles between SFD and payload.
REQ-021 o_TxER SHALL equal i_Err of the accepted byte for that byte's cycle only; the FCS is still appended.
REQ-022 Underrun (o_Ready=1 and i_Valid=0 while in DATA) SHALL go to ABORT and drive one cycle of o_TxEN=1, o_TxER=1, o8_TxD=0xFF, with an o_Underrun pulse, then enter GAP; no FCS is sent.
REQ-023 A 14-bit byte counter SHALL count data plus pad, saturating at 16383.
REQ-024 After i_Last is accepted, if count < MIN_FRAME, PAD SHALL drive 0x00 until count = MIN_FRAME; otherwise go directly to FCS.
REQ-025 FCS SHALL be IEEE 802.3 CRC-32 (reflected poly 0x04C11DB7, init 0xFFFFFFFF, final complement) over data plus pad, sent as 4 bytes with the least significant byte first.
REQ-026 The CRC register SHALL be reinitialised in SFD and updated on every data and pad byte, including errored bytes.
REQ-027 GAP SHALL hold o_TxEN=0 and o8_TxD=0x00 for exactly IFG cycles, then return to IDLE; i_Valid during GAP is ignored until IDLE.
REQ-028 With i_Valid held high across frames, consecutive frames SHALL be separated by exactly IFG+1 cycles with o_TxEN=0, counting the IDLE sampling cycle.
REQ-029 i_Last with i_Valid=0 SHALL be ignored, and i_Err outside DATA SHALL be ignored.

Reset
REQ-030 Asserting i_Reset at any point, including mid-frame, SHALL immediately force the FSM to IDLE, all outputs to 0, and the counter and CRC to initial values; the partial frame is not completed.
REQ-031 The first frame after reset deassertion SHALL be well-formed; no stale state carries over.

Structure
REQ-032 Package gmii_pkg SHALL hold the FSM state enum and the constants PREAMBLE=0x55, SFD=0xD5, CRC_INIT=0xFFFFFFFF, CRC_POLY=0xEDB88320 (reflected), CRC_RESIDUE=0xC704DD7B and ABORT_CODE=0xFF.
REQ-033 Sub-module crc32_d8 SHALL be combinational: a 32-bit state and 8-bit data in, the next 32-bit state out.

Verification
REQ-034 64-byte frame 0x00..0x3F -> 7x0x55, 0xD5, 64 bytes, 4 FCS bytes equal to the software CRC; o_TxEN high 76 cycles, then 12 low.
REQ-035 1-byte frame 0xAA -> 59x0x00 pad; o_TxEN high 72 cycles; bench receive model CRC over data+FCS = 0xC704DD7B.
REQ-036 Two 100-byte frames with i_Valid held -> exactly 13 o_TxEN=0 cycles between frames; both FCS values correct.
REQ-037 i_Valid dropped at payload byte 10 -> one cycle of TxEN=1/TxER=1/TxD=0xFF, o_Underrun pulse, no FCS, then 12 idle cycles.
REQ-038 i_Err on payload byte 5 of a 64-byte frame -> o_TxER high on that byte only; FCS still present and computed over the transmitted bytes.
REQ-039 i_Reset pulsed during the 2nd FCS byte -> all outputs 0 in the same cycle; the next 60-byte frame is transmitted correctly.

Source files
------------

// File: rtl/gmii_pkg.sv
// Shared types and constants for the GMII transmit framer.
package gmii_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_SFD,
    ST_DATA,
    ST_PAD,
    ST_FCS,
    ST_ABORT,
    ST_GAP
  } state_t;

  localparam logic [7:0]  PREAMBLE     = 8'h55;
  localparam logic [7:0]  SFD          = 8'hD5;
  localparam logic [7:0]  ABORT_CODE   = 8'hFF;
  localparam logic [31:0] CRC_INIT     = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_POLY     = 32'hEDB8_8320;
  localparam logic [31:0] CRC_RESIDUE  = 32'hC704_DD7B;
  localparam int unsigned PREAMBLE_LEN = 7;

  function automatic logic [13:0] sat_inc(input logic [13:0] v);
    return (v == '1) ? v : v + 14'd1;
  endfunction

  // FCS is the complemented CRC register, least significant byte first.
  function automatic logic [7:0] fcs_byte(input logic [31:0] crc, input logic [1:0] idx);
    logic [31:0] fcs;
    fcs = ~crc;
    return fcs[{idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/crc32_d8.sv
// Combinational one-byte step of the reflected IEEE 802.3 CRC-32.
module crc32_d8
  import gmii_pkg::*;
(
  input  logic [31:0] crc,
  input  logic [7:0]  data,
  output logic [31:0] next_crc
);

  always_comb begin
    next_crc = crc ^ {24'd0, data};
    for (int unsigned i = 0; i < 8; i++) begin
      next_crc = next_crc[0] ? ((next_crc >> 1) ^ CRC_POLY) : (next_crc >> 1);
    end
  end

endmodule

// File: rtl/gmii_tx_framer.sv
// GMII transmit framer: preamble/SFD, payload, zero pad to minimum length,
// CRC-32 FCS, underrun abort and inter-frame gap.
module gmii_tx_framer
  import gmii_pkg::*;
#(
  parameter int MIN_FRAME = 60,
  parameter int IFG       = 12
) (
  input  logic       i_TxClk,
  input  logic       i_Reset,
  input  logic [7:0] i8_Data,
  input  logic       i_Valid,
  input  logic       i_Last,
  input  logic       i_Err,
  output logic       o_Ready,
  output logic [7:0] o8_TxD,
  output logic       o_TxEN,
  output logic       o_TxER,
  output logic       o_Underrun
);

  localparam logic [13:0] MIN_CNT = 14'(MIN_FRAME);
  localparam logic [15:0] GAP_LEN = 16'(IFG);

  state_t      state;
  logic [2:0]  pre_cnt;
  logic [13:0] byte_cnt;
  logic [31:0] crc;
  logic [31:0] crc_next;
  logic [7:0]  crc_data;
  logic [1:0]  fcs_idx;
  logic [15:0] gap_cnt;

  // Ready is only high while a payload byte can be accepted; otherwise
  // the byte entering the CRC is a pad zero.
  assign crc_data = o_Ready ? i8_Data : 8'h00;

  crc32_d8 u_crc (
    .crc      (crc),
    .data     (crc_data),
    .next_crc (crc_next)
  );

  always_ff @(posedge i_TxClk or posedge i_Reset) begin
    if (i_Reset) begin
      state      <= ST_IDLE;
      o_Ready    <= 1'b0;
      o8_TxD     <= '0;
      o_TxEN     <= 1'b0;
      o_TxER     <= 1'b0;
      o_Underrun <= 1'b0;
      pre_cnt    <= '0;
      byte_cnt   <= '0;
      crc        <= CRC_INIT;
      fcs_idx    <= '0;
      gap_cnt    <= '0;
    end else begin
      o_TxER     <= 1'b0;
      o_Underrun <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (i_Valid) begin
            state   <= ST_PREAMBLE;
            o_TxEN  <= 1'b1;
            o8_TxD  <= PREAMBLE;
            pre_cnt <= 3'd1;
          end
        end
        ST_PREAMBLE: begin
          if (pre_cnt == 3'(PREAMBLE_LEN)) begin
            state    <= ST_SFD;
            o8_TxD   <= SFD;
            o_Ready  <= 1'b1;
            crc      <= CRC_INIT;
            byte_cnt <= '0;
          end else begin
            pre_cnt <= pre_cnt + 3'd1;
          end
        end
        // While ready, a byte is accepted or the frame underruns; once the
        // last byte is out, the same path pads and then starts the FCS.
        ST_SFD, ST_DATA, ST_PAD: begin
          if (o_Ready) begin
            if (i_Valid) begin
              state    <= ST_DATA;
              o8_TxD   <= i8_Data;
              o_TxER   <= i_Err;
              crc      <= crc_next;
              byte_cnt <= sat_inc(byte_cnt);
              if (i_Last) o_Ready <= 1'b0;
            end else begin
              state      <= ST_ABORT;
              o8_TxD     <= ABORT_CODE;
              o_TxER     <= 1'b1;
              o_Underrun <= 1'b1;
              o_Ready    <= 1'b0;
            end
          end else if (byte_cnt < MIN_CNT) begin
            state    <= ST_PAD;
            o8_TxD   <= 8'h00;
            crc      <= crc_next;
            byte_cnt <= sat_inc(byte_cnt);
          end else begin
            state   <= ST_FCS;
            o8_TxD  <= fcs_byte(crc, 2'd0);
            fcs_idx <= 2'd1;
          end
        end
        ST_FCS: begin
          // fcs_idx wraps to 0 after the fourth byte has been driven.
          if (fcs_idx == 2'd0) begin
            state   <= ST_GAP;
            o_TxEN  <= 1'b0;
            o8_TxD  <= 8'h00;
            gap_cnt <= 16'd1;
          end else begin
            o8_TxD  <= fcs_byte(crc, fcs_idx);
            fcs_idx <= fcs_idx + 2'd1;
          end
        end
        ST_ABORT: begin
          state   <= ST_GAP;
          o_TxEN  <= 1'b0;
          o8_TxD  <= 8'h00;
          gap_cnt <= 16'd1;
        end
        ST_GAP: begin
          if (gap_cnt >= GAP_LEN) begin
            state <= ST_IDLE;
          end else begin
            gap_cnt <= gap_cnt + 16'd1;
          end
        end
        default: begin
          state   <= ST_IDLE;
          o_TxEN  <= 1'b0;
          o_Ready <= 1'b0;
          o8_TxD  <= 8'h00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gmii_tx_framer.sv
// Self-checking bench for gmii_tx_framer: a frame-level expected-byte model
// compared against the GMII outputs every cycle.
module tb_gmii_tx_framer;

  localparam int MIN_FRAME = 60;
  localparam int IFG       = 12;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] din = 8'h00;
  logic       valid = 1'b0;
  logic       last = 1'b0;
  logic       err = 1'b0;
  logic       ready;
  logic [7:0] txd;
  logic       txen;
  logic       txer;
  logic       und;

  gmii_tx_framer #(.MIN_FRAME(MIN_FRAME), .IFG(IFG)) dut (
    .i_TxClk    (clk),
    .i_Reset    (rst),
    .i8_Data    (din),
    .i_Valid    (valid),
    .i_Last     (last),
    .i_Err      (err),
    .o_Ready    (ready),
    .o8_TxD     (txd),
    .o_TxEN     (txen),
    .o_TxER     (txer),
    .o_Underrun (und)
  );

  always #4 clk = ~clk;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int len;
    bit aborted;
    bit b2b;
  } meta_t;

  // Each expected cycle: {ready, underrun, txer, txd}
  logic [10:0] exp_q[$];
  meta_t       meta_q[$];
  logic [7:0]  pay[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: actual=%h expected=%h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c;
    for (int k = 0; k < 8; k++) begin
      if (r[0] ^ b[k]) r = (r >> 1) ^ 32'hEDB88320;
      else             r = r >> 1;
    end
    return r;
  endfunction

  function automatic logic [31:0] bitrev32(input logic [31:0] c);
    logic [31:0] r;
    for (int k = 0; k < 32; k++) r[k] = c[31-k];
    return r;
  endfunction

  // Expected wire image of one frame, built from the framing rules.
  task automatic build_frame(input int len, input int err_idx, input int drop_idx, input bit b2b);
    logic [31:0] c;
    logic [31:0] fcs;
    meta_t m;
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < 7; i++) exp_q.push_back({3'b000, 8'h55});
    exp_q.push_back({3'b100, 8'hD5});
    if (drop_idx >= 0) begin
      for (int i = 0; i < drop_idx; i++)
        exp_q.push_back({1'b1, 1'b0, (i == err_idx), pay[i]});
      exp_q.push_back({3'b011, 8'hFF});
      m.len = 8 + drop_idx + 1;
      m.aborted = 1'b1;
    end else begin
      for (int i = 0; i < len; i++) begin
        exp_q.push_back({(i != len - 1), 1'b0, (i == err_idx), pay[i]});
        c = crc_step(c, pay[i]);
      end
      for (int i = len; i < MIN_FRAME; i++) begin
        exp_q.push_back({3'b000, 8'h00});
        c = crc_step(c, 8'h00);
      end
      fcs = ~c;
      for (int i = 0; i < 4; i++) exp_q.push_back({3'b000, fcs[8*i +: 8]});
      m.len = 8 + ((len > MIN_FRAME) ? len : MIN_FRAME) + 4;
      m.aborted = 1'b0;
    end
    m.b2b = b2b;
    meta_q.push_back(m);
  endtask

  // Receiver / compare process
  bit          in_frame = 1'b0;
  bit          gap_valid = 1'b0;
  int          gap_cnt = 0;
  int          txen_len = 0;
  int          last_len = 0;
  int          last_gap = 0;
  meta_t       cur;
  logic [7:0]  rx[$];

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      meta_q.delete();
      rx.delete();
      in_frame = 1'b0;
      gap_valid = 1'b0;
    end else if (txen) begin
      if (!in_frame) begin
        in_frame = 1'b1;
        txen_len = 0;
        rx.delete();
        if (meta_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_frame: TxEN rose with no frame queued at %0t", $time);
          cur.len = 0; cur.aborted = 1'b1; cur.b2b = 1'b0;
        end else begin
          cur = meta_q.pop_front();
        end
        if (gap_valid) begin
          last_gap = gap_cnt;
          if (cur.b2b) begin
            check("ifg_back_to_back", 32'(gap_cnt), 32'(IFG + 1));
          end else begin
            tests++;
            if (gap_cnt < IFG + 1) begin
              fails++;
              $display("FAIL ifg_min: actual=%0d expected>=%0d", gap_cnt, IFG + 1);
            end
          end
        end
      end
      txen_len++;
      rx.push_back(txd);
      if (exp_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL extra_byte: actual=%h expected=none at %0t", txd, $time);
      end else begin
        check("tx_cycle", 32'({ready, und, txer, txd}), 32'(exp_q.pop_front()));
      end
    end else begin
      check("idle_outputs", 32'({ready, und, txer, txd}), 32'h0);
      if (in_frame) begin
        logic [31:0] c;
        in_frame = 1'b0;
        last_len = txen_len;
        check("frame_len", 32'(txen_len), 32'(cur.len));
        if (!cur.aborted) begin
          c = 32'hFFFF_FFFF;
          for (int i = 8; i < rx.size(); i++) c = crc_step(c, rx[i]);
          check("rx_residue", bitrev32(c), 32'hC704DD7B);
        end
        gap_cnt = 1;
        gap_valid = 1'b1;
      end else begin
        gap_cnt++;
      end
    end
  end

  // Driver
  task automatic send_frame(input int len, input int err_idx, input int drop_idx);
    int idx;
    int cyc;
    bit acc;
    idx = 0;
    cyc = 0;
    forever begin
      @(negedge clk);
      if (drop_idx >= 0 && idx == drop_idx && ready) begin
        valid = 1'b0;
        last = 1'($urandom);
        err = 1'($urandom);
        din = 8'($urandom);
        @(posedge clk);
        return;
      end
      valid = 1'b1;
      din = pay[idx];
      last = (idx == len - 1);
      err = (idx == err_idx);
      acc = ready;
      @(posedge clk);
      if (acc) begin
        if (idx == len - 1) return;
        idx++;
      end
      cyc++;
      if (cyc > 3000) begin
        tests++; fails++;
        $display("FAIL send_timeout: stalled at byte %0d of %0d", idx, len);
        return;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      valid = 1'b0;
      last = 1'($urandom);
      err = 1'($urandom);
      din = 8'($urandom);
    end
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    @(negedge clk);
    valid = 1'b0;
    while ((exp_q.size() != 0 || meta_q.size() != 0 || in_frame) && k < 1000) begin
      @(negedge clk);
      k++;
    end
    if (k >= 1000) begin
      tests++; fails++;
      $display("FAIL drain_timeout: actual=%0d bytes pending expected=0", exp_q.size());
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic fill_random(input int len);
    pay.delete();
    for (int i = 0; i < len; i++) pay.push_back(8'($urandom));
  endtask

  initial begin
    logic [31:0] c;
    logic [7:0]  ascii [9];

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_state", 32'({ready, und, txer, txen, txd}), 32'h0);
    rst = 1'b0;

    // Standard CRC-32 check value of "123456789"
    for (int i = 0; i < 9; i++) ascii[i] = 8'(8'h31 + i);
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < 9; i++) c = crc_step(c, ascii[i]);
    check("crc_check_value", ~c, 32'hCBF43926);

    idle(4);

    // 64-byte incrementing frame
    pay.delete();
    for (int i = 0; i < 64; i++) pay.push_back(8'(i));
    build_frame(64, -1, -1, 1'b0);
    send_frame(64, -1, -1);
    wait_done();
    check("len_64_frame", 32'(last_len), 32'd76);

    // 1-byte frame, padded to minimum
    pay.delete();
    pay.push_back(8'hAA);
    build_frame(1, -1, -1, 1'b0);
    send_frame(1, -1, -1);
    wait_done();
    check("len_1_frame", 32'(last_len), 32'd72);

    // Two 100-byte frames with valid held high
    fill_random(100);
    build_frame(100, -1, -1, 1'b0);
    send_frame(100, -1, -1);
    fill_random(100);
    build_frame(100, -1, -1, 1'b1);
    send_frame(100, -1, -1);
    wait_done();
    check("b2b_gap_cycles", 32'(last_gap), 32'd13);

    // Underrun at payload byte 10
    fill_random(64);
    build_frame(64, -1, 10, 1'b0);
    send_frame(64, -1, 10);
    wait_done();
    check("len_underrun", 32'(last_len), 32'd19);

    // Errored byte 5 of a 64-byte frame
    fill_random(64);
    build_frame(64, 5, -1, 1'b0);
    send_frame(64, 5, -1);
    wait_done();
    check("len_err_frame", 32'(last_len), 32'd76);

    // Reset during the second FCS byte of a 60-byte frame
    fill_random(60);
    build_frame(60, -1, -1, 1'b0);
    send_frame(60, -1, -1);
    @(negedge clk);
    valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("reset_midframe", 32'({ready, und, txer, txen, txd}), 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    idle(3);
    fill_random(60);
    build_frame(60, -1, -1, 1'b0);
    send_frame(60, -1, -1);
    wait_done();
    check("len_after_reset", 32'(last_len), 32'd72);

    // Randomized frames
    for (int f = 0; f < 24; f++) begin
      int len;
      int e;
      int d;
      bit b;
      len = int'($urandom_range(1, 150));
      e = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, len - 1)) : -1;
      d = (len >= 2 && $urandom_range(0, 4) == 0) ? int'($urandom_range(1, len - 1)) : -1;
      b = (f != 0) && ($urandom_range(0, 1) == 1);
      if (!b) idle(int'($urandom_range(0, 20)));
      fill_random(len);
      build_frame(len, e, d, b);
      send_frame(len, e, d);
    end
    wait_done();
    check("queue_drained", 32'(exp_q.size() + meta_q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1);
  end

endmodule
